instr_fetch_unit: RTL

// - Parametrised in-order instruction fetch unit; sits between the PC/redirect logic and the imem port.
// - Successor to the single-outstanding fetch path:
//   - keeps up to MAX_OUTSTANDING imem requests in flight;
//   - buffers responses in a FIFO with the PC of each instruction;
//   - flushes cleanly on redirect (branch/jump/trap), dropping stale responses.
// - Presents a valid/ready instruction stream to the decode stage.

---
 rtl/core_types_pkg.sv | 13 +
 rtl/memory_types_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/instr_fetch_unit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/core_types_pkg.sv
// Core-wide types: machine word width, fetch buffer entry layout and the default fetch buffer
// depth.
package core_types_pkg;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned IFU_DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/memory_types_pkg.sv
// Memory port packet types shared by imem/dmem clients.
// mem_pkt_t carries the request/response: transaction type, byte address, burst length (0 = single
// beat) and data word.
package memory_types_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_LEN_W  = 8;

  typedef enum logic [1:0] {
    READ  = 2'd0,
    WRITE = 2'd1
  } mem_type_e;

  typedef struct packed {
    mem_type_e               mtype;
    logic [MEM_ADDR_W-1:0]   addr;
    logic [MEM_LEN_W-1:0]    len;
    logic [MEM_DATA_W-1:0]   data;
  } mem_pkt_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage (read data is never combinationally fed from wdata_i).
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_i             empties the FIFO; a push or pop in the same cycle is ignored
//   push_i / wdata_i    write request and data; accepted when not full or when popping
//   pop_i / rdata_o     read request and head-of-queue data; pop on empty is ignored
//   count_o             number of stored entries
//   full_o / empty_o    status flags
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i) begin
      assert (!(push_i && full_o && !do_pop))
        else $error("sync_fifo: push into full buffer");
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// In-order instruction fetch unit between the PC/redirect logic and the imem port. Keeps up to
// MAX_OUTSTANDING reads in flight, buffers responses with their PCs, and flushes on redirect,
// discarding responses to requests issued before the redirect.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   redirect_vld / redirect_pc        load new fetch PC, flush buffer and in-flight responses
//   imem_req_vld/_rdy, imem_req       read request (addr = fetch PC)
//   imem_rsp_vld/_rdy, imem_rsp       in-order read response (.data = instruction)
//   instr_vld/_rdy, instr, instr_pc   instruction stream to decode
// Configuration:
//   IFU_FIFO_BYPASS_EN  when defined, a response arriving at an empty buffer is presented to decode
//                       in the same cycle; otherwise instr* come only from the registered buffer.
// N_BITS must equal core_types_pkg::XLEN (buffer entries use fetch_entry_t).
module instr_fetch_unit
  import core_types_pkg::*;
  import memory_types_pkg::*;
#(
  parameter int unsigned       N_BITS          = XLEN,
  parameter logic [N_BITS-1:0] RESET_PC        = '0,
  parameter int unsigned       MAX_OUTSTANDING = 2,
  parameter int unsigned       FIFO_DEPTH      = IFU_DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_vld,
  input  logic [N_BITS-1:0] redirect_pc,
  output logic              imem_req_vld,
  input  logic              imem_req_rdy,
  output mem_pkt_t          imem_req,
  input  logic              imem_rsp_vld,
  output logic              imem_rsp_rdy,
  input  mem_pkt_t          imem_rsp,
  output logic              instr_vld,
  input  logic              instr_rdy,
  output logic [N_BITS-1:0] instr,
  output logic [N_BITS-1:0] instr_pc
);

  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [N_BITS-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [OutW-1:0]   outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0]   fifo_count;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic              req_fire, rsp_fire, rsp_keep, bypass;
  fetch_entry_t      push_entry, head_entry;

  // Issue only while every in-flight request is guaranteed a buffer slot.
  assign imem_req_vld = !rst && !redirect_vld
                        && (int'(outstanding_q) + int'(fifo_count) < int'(FIFO_DEPTH))
                        && (int'(outstanding_q) < int'(MAX_OUTSTANDING));
  assign imem_rsp_rdy = !rst;

  always_comb begin
    imem_req       = '0;
    imem_req.mtype = READ;
    imem_req.addr  = fetch_pc_q;
  end

  assign req_fire = imem_req_vld && imem_req_rdy;
  assign rsp_fire = imem_rsp_vld && imem_rsp_rdy;
  assign rsp_keep = rsp_fire && (drop_cnt_q == '0) && !redirect_vld;

`ifdef IFU_FIFO_BYPASS_EN
  assign bypass = rsp_keep && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign push_entry.pc    = rsp_pc_q;
  assign push_entry.instr = imem_rsp.data;
  // A bypassed response consumed by decode this cycle never enters the buffer.
  assign fifo_push = rsp_keep && !(bypass && instr_rdy);
  assign fifo_pop  = !fifo_empty && instr_rdy && !redirect_vld;

  assign instr_vld = !fifo_empty || bypass;

  always_comb begin
    instr    = '0;
    instr_pc = '0;
    if (!fifo_empty) begin
      instr    = head_entry.instr;
      instr_pc = head_entry.pc;
    end
`ifdef IFU_FIFO_BYPASS_EN
    else if (bypass) begin
      instr    = imem_rsp.data;
      instr_pc = rsp_pc_q;
    end
`endif
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + OutW'(req_fire) - OutW'(rsp_fire);
    if (req_fire) fetch_pc_d = fetch_pc_q + N_BITS'(4);
    if (rsp_keep) rsp_pc_d = rsp_pc_q + N_BITS'(4);
    if (rsp_fire && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - OutW'(1);
    // Every request still in flight after this edge belongs to the old stream.
    if (redirect_vld) begin
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      drop_cnt_d = outstanding_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (int'(outstanding_q) + int'(fifo_count) <= int'(FIFO_DEPTH))
        else $error("instr_fetch_unit: in-flight plus buffered exceeds buffer depth");
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (redirect_vld),
    .push_i  (fifo_push),
    .wdata_i (push_entry),
    .pop_i   (fifo_pop),
    .rdata_o (head_entry),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  logic unused_sig;
  assign unused_sig = ^{imem_rsp.mtype, imem_rsp.addr, imem_rsp.len, fifo_full};

endmodule
